// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder: FSM state
//               encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Operand/result width used when the instantiating code gives none.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. The encoding is fixed so that it can be decoded
  // from a waveform without symbol information.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : 1-bit full-adder cell; the only arithmetic element of the
//               bit-serial adder.
// Ports       : a, b, ci  - addend bits and carry-in
//               s         - sum bit
//               co        - carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial two's-complement adder. An operation is accepted
//               with a valid/ready handshake, processed one bit per clock
//               through a single full-adder cell (LSB first), and presented
//               with a valid/ready handshake until the consumer takes it.
//               One operation completes every WIDTH+2 cycles at best.
// Parameters  : WIDTH        - operand/result width in bits (2..64)
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               start_valid  - requester presents an operation
//               start_ready  - block can accept (IDLE and not in reset)
//               op_a, op_b   - addends, sampled at accept
//               cin          - carry-in, sampled at accept
//               sub          - (SERIAL_ADDER_SUB_EN only) subtract op_b
//               result       - registered sum
//               cout         - registered carry-out of the MSB
//               ovf          - registered two's-complement overflow
//               done_valid   - result/cout/ovf are valid
//               done_ready   - consumer takes the result
// Macro       : SERIAL_ADDER_SUB_EN - adds the sub port; sub=1 computes
//               op_a - op_b (cin ignored), cout then means "no borrow".
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready
);

  // Counter must be able to hold WIDTH after the last bit is processed.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_BIT  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              c_msb_q, c_msb_d;   // carry into bit WIDTH-1
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              fa_sum;
  logic              fa_co;

  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

  // --------------------------------------------------------------------------
  // Operand conditioning at accept. Subtraction is a + ~b + 1, so the
  // inverted addend and a forced carry-in are all that is needed.
  // --------------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub ? 1'b1  : cin;
`else
  assign b_load     = op_b;
  assign carry_load = cin;
`endif

  // --------------------------------------------------------------------------
  // Single arithmetic cell, fed from the LSBs of the operand shifters.
  // --------------------------------------------------------------------------
  full_adder u_full_adder (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_sum),
    .co (fa_co)
  );

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        // start_ready is IDLE & ~rst; an edge only happens here with rst
        // low, so start_valid alone qualifies the accept.
        if (start_valid) begin
          a_d     = op_a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          c_msb_d = 1'b0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of the
        // sum has reached result[0].
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_ONE;

        // The carry out of bit WIDTH-2 is the carry into the sign bit.
        if (cnt_q == PENULT_BIT) begin
          c_msb_d = fa_co;
        end

        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
          ovf_d   = c_msb_q ^ fa_co;
          state_d = DONE;
        end
      end

      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // rst is included so that ready drops the moment reset asserts rather
  // than at the next edge.
  assign start_ready = (state_q == IDLE) && !rst;
  assign done_valid  = (state_q == DONE);
  assign result      = res_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=8). A
//               transaction-level arithmetic model predicts the handshake
//               outputs and results every cycle; directed vectors also
//               carry hand-computed literal expectations.
// Macro       : SERIAL_ADDER_SUB_EN - connects sub and runs subtract vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk         = 1'b0;
  logic             rst         = 1'b1;
  logic             start_valid = 1'b0;
  logic             cin         = 1'b0;
  logic             done_ready  = 1'b0;
  logic [WIDTH-1:0] op_a        = '0;
  logic [WIDTH-1:0] op_b        = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub         = 1'b0;
`endif
  logic             start_ready;
  logic             cout;
  logic             ovf;
  logic             done_valid;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub         (sub),
`endif
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Arithmetic reference: returns {ovf, cout, sum}.
  // --------------------------------------------------------------------------
  function automatic logic [WIDTH+1:0] model_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic c,
                                                 input logic s);
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [WIDTH:0]   full;
    logic             ov;
    bb = b;
    cc = c;
`ifdef SERIAL_ADDER_SUB_EN
    if (s) begin
      bb = ~b;
      cc = 1'b1;
    end
`else
    if (s) cc = c;
`endif
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    // Overflow: both addends share a sign that the sum does not.
    ov = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ov, full};
  endfunction

  // --------------------------------------------------------------------------
  // Transaction model: 0 = waiting, 1 = busy for WIDTH edges, 2 = holding.
  // --------------------------------------------------------------------------
  int               m_phase = 0;
  int               m_cnt   = 0;
  logic [WIDTH-1:0] m_res   = '0;
  logic             m_cout  = 1'b0;
  logic             m_ovf   = 1'b0;
  logic [WIDTH+1:0] m_pend  = '0;
  logic             cur_sub;

`ifdef SERIAL_ADDER_SUB_EN
  assign cur_sub = sub;
`else
  assign cur_sub = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_res   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start_valid) begin
             m_pend  <= model_sum(op_a, op_b, cin, cur_sub);
             m_cnt   <= 0;
             m_phase <= 1;
           end
        1: begin
             m_cnt <= m_cnt + 1;
             if (m_cnt + 1 == WIDTH) begin
               m_phase <= 2;
               m_res   <= m_pend[WIDTH-1:0];
               m_cout  <= m_pend[WIDTH];
               m_ovf   <= m_pend[WIDTH+1];
             end
           end
        default: if (done_ready) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model; results are don't-care while busy.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("start_ready", {63'd0, start_ready}, {63'd0, (m_phase == 0) && !rst});
      check("done_valid",  {63'd0, done_valid},  {63'd0, m_phase == 2});
      if (m_phase != 1) begin
        check("result", {{(64-WIDTH){1'b0}}, result}, {{(64-WIDTH){1'b0}}, m_res});
        check("cout",   {63'd0, cout}, {63'd0, m_cout});
        check("ovf",    {63'd0, ovf},  {63'd0, m_ovf});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus. Tasks start and end 2 time units after a rising edge.
  // --------------------------------------------------------------------------
  task automatic wait_done(output int n);
    n = 0;
    while (!done_valid && n < 3 * WIDTH) begin
      @(posedge clk); #2;
      n++;
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s,
                       input logic [WIDTH-1:0] exp_r, input logic exp_co,
                       input logic exp_ov, input string tag);
    int n;
    op_a = a;
    op_b = b;
    cin  = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub  = s;
`else
    if (s) cin = c;
`endif
    start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(WIDTH));
    check({tag, "_result"}, {56'd0, result}, {56'd0, exp_r});
    check({tag, "_cout"},   {63'd0, cout}, {63'd0, exp_co});
    check({tag, "_ovf"},    {63'd0, ovf},  {63'd0, exp_ov});
    done_ready = 1'b1;
    @(posedge clk); #2;
    done_ready = 1'b0;
  endtask

  initial begin
    int n;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_result",      {56'd0, result}, 64'h0);
    check("rst_done_valid",  {63'd0, done_valid}, 64'h0);
    check("rst_start_ready", {63'd0, start_ready}, 64'h0);
    rst = 1'b0;
    #1;
    check("idle_start_ready", {63'd0, start_ready}, 64'h1);
    @(posedge clk); #2;

    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, "add_35_4a");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    do_op(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_00_c1");
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80");

    // Back-pressure: hold the result while a new request is pending.
    op_a = 8'h12; op_b = 8'h34; cin = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #2;
    op_a = 8'h01; op_b = 8'h02; cin = 1'b0;
    wait_done(n);
    check("bp_latency", 64'(n), 64'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("bp_hold_result", {56'd0, result}, 64'h47);
      check("bp_hold_valid",  {63'd0, done_valid}, 64'h1);
      check("bp_hold_ready",  {63'd0, start_ready}, 64'h0);
    end
    done_ready = 1'b1;
    @(posedge clk); #2;
    done_ready = 1'b0;
    check("bp_idle_ready", {63'd0, start_ready}, 64'h1);
    @(posedge clk); #2;
    start_valid = 1'b0;
    check("bp_accepted", {63'd0, start_ready}, 64'h0);
    wait_done(n);
    check("bp2_latency", 64'(n), 64'(WIDTH));
    check("bp2_result", {56'd0, result}, 64'h03);
    done_ready = 1'b1;
    @(posedge clk); #2;
    done_ready = 1'b0;

    // Abort mid-operation with reset.
    op_a = 8'hAA; op_b = 8'h55; cin = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_result",      {56'd0, result}, 64'h0);
    check("abort_cout",        {63'd0, cout}, 64'h0);
    check("abort_ovf",         {63'd0, ovf}, 64'h0);
    check("abort_done_valid",  {63'd0, done_valid}, 64'h0);
    check("abort_start_ready", {63'd0, start_ready}, 64'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    do_op(8'h10, 8'h22, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0, "post_abort");

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    sub = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
`default_nettype wire
